// File: rtl/reset_sequencer_pkg.sv
// Shared types for the reset sequencer.
//   state_e : sequencer FSM states
//   cause_e : encoding of reset_cause (what started the most recent reset)
package reset_sequencer_pkg;

    typedef enum logic [2:0] {
        StAssert,
        StWaitLock,
        StHold,
        StRelease,
        StRun
    } state_e;

    typedef enum logic [1:0] {
        CausePor    = 2'd0,
        CauseButton = 2'd1,
        CausePll    = 2'd2,
        CauseSw     = 2'd3
    } cause_e;

endpackage

// File: rtl/reset_sequencer_if.sv
// Board-side signals of the reset sequencer.
//   button_n     : raw active-low push-button (async, bouncy)
//   pll_locked   : PLL lock indication (async to clk)
//   sw_reset_req : single-cycle synchronous software reset request
//   rst_n_stage  : sequenced active-low reset outputs, one per clock domain
//   reset_active : high while any stage is held in reset
//   reset_cause  : cause of the most recent reset
// Modports: master = the sequencer, slave = the board / environment.
interface reset_sequencer_if #(
    parameter int unsigned NUM_STAGES = 3
);
    import reset_sequencer_pkg::*;

    logic                  button_n;
    logic                  pll_locked;
    logic                  sw_reset_req;
    logic [NUM_STAGES-1:0] rst_n_stage;
    logic                  reset_active;
    cause_e                reset_cause;

    modport master (
        input  button_n,
        input  pll_locked,
        input  sw_reset_req,
        output rst_n_stage,
        output reset_active,
        output reset_cause
    );

    modport slave (
        output button_n,
        output pll_locked,
        output sw_reset_req,
        input  rst_n_stage,
        input  reset_active,
        input  reset_cause
    );

endinterface

// File: rtl/reset_sequencer_sync_debounce.sv
// Two-flop synchronizer followed by a stable-level debouncer.
//   clk, rst_n : clock and async active-low reset
//   din        : asynchronous input level
//   level      : debounced level; follows din only after CYCLES consecutive
//                synchronized samples of the new value
//   rise       : one-cycle pulse, registered together with level going 0->1
module reset_sequencer_sync_debounce #(
    parameter int unsigned CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int unsigned     CntW    = $clog2(CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(CYCLES - 1);

    logic            meta_q;
    logic            sync_q;
    logic            level_q;
    logic            rise_q;
    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            rise_q <= 1'b0;
            if (sync_q == level_q) begin
                // Any sample matching the current level restarts the window.
                cnt_q <= '0;
            end else if (cnt_q >= CntLast) begin
                level_q <= sync_q;
                rise_q  <= sync_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/reset_sequencer.sv
// Central reset controller on the board reference clock.
// Merges button, PLL-lock loss and software requests into one reset event,
// waits for a stable PLL lock plus a hold period, then releases the
// active-low stage resets one by one, STAGE_GAP cycles apart.
//   clk, rst_n : reference clock and async active-low power-on reset
//   bus        : reset_sequencer_if.master (inputs button_n, pll_locked,
//                sw_reset_req; outputs rst_n_stage, reset_active, reset_cause)
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int unsigned NUM_STAGES         = 3,
    parameter int unsigned DEBOUNCE_CYCLES    = 50000,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned HOLD_CYCLES        = 256,
    parameter int unsigned STAGE_GAP          = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    reset_sequencer_if.master        bus
);

    localparam int unsigned     LockW    = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int unsigned     HoldW    = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned     GapW     = $clog2(STAGE_GAP + 1);
    localparam int unsigned     IdxW     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [LockW-1:0] LockLast = LockW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
    localparam logic [GapW-1:0]  GapLast  = GapW'(STAGE_GAP - 1);
    localparam logic [IdxW-1:0]  LastIdx  = IdxW'(NUM_STAGES - 1);

    logic pll_meta_q;
    logic pll_sync_q;
    logic btn_pressed;
    logic btn_rise;

    state_e                state_q;
    logic [LockW-1:0]      lock_cnt_q;
    logic [HoldW-1:0]      hold_cnt_q;
    logic [GapW-1:0]       gap_cnt_q;
    logic [IdxW-1:0]       idx_q;
    logic [NUM_STAGES-1:0] stage_q;
    logic                  active_q;
    cause_e                cause_q;

    logic   evt;
    cause_e evt_cause;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pll_meta_q <= 1'b0;
            pll_sync_q <= 1'b0;
        end else begin
            pll_meta_q <= bus.pll_locked;
            pll_sync_q <= pll_meta_q;
        end
    end

    reset_sequencer_sync_debounce #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_button (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (~bus.button_n),
        .level (btn_pressed),
        .rise  (btn_rise)
    );

    // Lock can only be lost once it was required (HOLD onwards), so the
    // low synchronized level there is equivalent to a falling edge.
    always_comb begin
        evt       = 1'b0;
        evt_cause = CausePor;
        if (state_q != StAssert) begin
            if (!pll_sync_q && (state_q inside {StHold, StRelease, StRun})) begin
                evt       = 1'b1;
                evt_cause = CausePll;
            end else if (btn_rise) begin
                evt       = 1'b1;
                evt_cause = CauseButton;
            end else if (bus.sw_reset_req) begin
                evt       = 1'b1;
                evt_cause = CauseSw;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StAssert;
            lock_cnt_q <= '0;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
            idx_q      <= '0;
            stage_q    <= '0;
            active_q   <= 1'b1;
            cause_q    <= CausePor;
        end else if (evt) begin
            state_q    <= StAssert;
            lock_cnt_q <= '0;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
            idx_q      <= '0;
            stage_q    <= '0;
            active_q   <= 1'b1;
            cause_q    <= evt_cause;
        end else begin
            unique case (state_q)
                StAssert: begin
                    lock_cnt_q <= '0;
                    hold_cnt_q <= '0;
                    state_q    <= StWaitLock;
                end
                StWaitLock: begin
                    // A held button blocks counting just like a missing lock.
                    if (pll_sync_q && !btn_pressed) begin
                        if (lock_cnt_q >= LockLast) begin
                            lock_cnt_q <= '0;
                            hold_cnt_q <= '0;
                            state_q    <= StHold;
                        end else begin
                            lock_cnt_q <= lock_cnt_q + 1'b1;
                        end
                    end else begin
                        lock_cnt_q <= '0;
                    end
                end
                StHold: begin
                    if (hold_cnt_q >= HoldLast) begin
                        gap_cnt_q <= '0;
                        idx_q     <= '0;
                        state_q   <= StRelease;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                StRelease: begin
                    if (gap_cnt_q == '0) begin
                        stage_q[idx_q] <= 1'b1;
                        if (idx_q == LastIdx) begin
                            active_q <= 1'b0;
                            state_q  <= StRun;
                        end else begin
                            idx_q     <= idx_q + 1'b1;
                            gap_cnt_q <= GapLast;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 1'b1;
                    end
                end
                StRun: begin
                    stage_q  <= '1;
                    active_q <= 1'b0;
                end
                default: begin
                    stage_q  <= '0;
                    active_q <= 1'b1;
                    state_q  <= StAssert;
                end
            endcase
        end
    end

    assign bus.rst_n_stage  = stage_q;
    assign bus.reset_active = active_q;
    assign bus.reset_cause  = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer with small timing parameters.
// Expected timing (edges counted from the reference point):
//   first lock-counting edge F -> stage0 at F + LOCK + HOLD,
//   stage i at stage0 + i*GAP, reset_active falls with the last stage.
module tb_reset_sequencer;

    localparam int unsigned NS   = 3;
    localparam int unsigned DEB  = 8;
    localparam int unsigned LOCK = 10;
    localparam int unsigned HOLD = 5;
    localparam int unsigned GAP  = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    reset_sequencer_if #(.NUM_STAGES(NS)) bus ();

    reset_sequencer #(
        .NUM_STAGES         (NS),
        .DEBOUNCE_CYCLES    (DEB),
        .LOCK_STABLE_CYCLES (LOCK),
        .HOLD_CYCLES        (HOLD),
        .STAGE_GAP          (GAP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string name;
        int    value;
    } exp_t;

    // kind: 0 software pulse, 1 PLL pin low, 2 button low.
    // hold: extra cycles the stimulus stays applied after the stages drop.
    // exp_rel: edges from the drop edge to stage0 release.
    typedef struct {
        string name;
        int    kind;
        int    hold;
        int    exp_drop;
        int    exp_cause;
        int    exp_rel;
    } vec_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string name, input int v);
        exp_t e;
        e.name  = name;
        e.value = v;
        sb_q.push_back(e);
    endtask

    task automatic observe(input int act);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: got %0d with nothing expected", act);
        end else begin
            e = sb_q.pop_front();
            if (act != e.value) begin
                failures++;
                $display("FAIL %s: got %0d, want %0d", e.name, act, e.value);
            end
        end
    endtask

    // Edges until stage idx reads 1; -1 if it never does within the budget.
    task automatic wait_rise(input int idx, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.rst_n_stage[idx] !== 1'b1 && n < 150);
        if (bus.rst_n_stage[idx] !== 1'b1) n = -1;
    endtask

    // Edges until all stages read 0 (sw request held for exactly one edge).
    task automatic wait_drop(output int n);
        n = 0;
        do begin
            tick();
            n++;
            bus.sw_reset_req = 1'b0;
        end while (bus.rst_n_stage != '0 && n < 40);
    endtask

    task automatic finish_release(input string tag);
        int n;
        expect_val({tag, "_gap1"}, GAP);
        wait_rise(1, n);
        observe(n);
        expect_val({tag, "_gap2"}, GAP);
        wait_rise(2, n);
        observe(n);
        expect_val({tag, "_active_run"}, 0);
        observe(int'(bus.reset_active));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   n;
        int   bad;

        vecs[0] = '{"sw",        0, 0,  1, 3, 17};
        vecs[1] = '{"pll",       1, 0,  3, 2, 18};
        vecs[2] = '{"pll_hold7", 1, 7,  3, 2, 25};
        vecs[3] = '{"btn",       2, 0, 11, 1, 26};
        vecs[4] = '{"btn_hold",  2, 40, 11, 1, 66};
        vecs[5] = '{"sw2",       0, 0,  1, 3, 17};

        bus.button_n     = 1'b1;
        bus.pll_locked   = 1'b1;
        bus.sw_reset_req = 1'b0;
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        repeat (5) tick();

        // Power-on reset values.
        expect_val("por_stages", 0);
        observe(int'(bus.rst_n_stage));
        expect_val("por_active", 1);
        observe(int'(bus.reset_active));
        expect_val("por_cause", 0);
        observe(int'(bus.reset_cause));

        // Release: sync done at edge 2, first counting edge 3 -> stage0 at 18.
        rst_n = 1'b1;
        expect_val("por_stage0", 3 + LOCK + HOLD);
        wait_rise(0, n);
        observe(n);
        expect_val("por_gap1", GAP);
        wait_rise(1, n);
        observe(n);
        expect_val("por_active_mid", 1);
        observe(int'(bus.reset_active));
        expect_val("por_gap2", GAP);
        wait_rise(2, n);
        observe(n);
        expect_val("por_active_run", 0);
        observe(int'(bus.reset_active));
        expect_val("por_cause_run", 0);
        observe(int'(bus.reset_cause));

        // Bouncing button: level never stable for DEB samples.
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            bus.button_n = ~bus.button_n;
            repeat (3) begin
                tick();
                if (bus.rst_n_stage != 3'b111) bad++;
            end
        end
        bus.button_n = 1'b1;
        repeat (12) begin
            tick();
            if (bus.rst_n_stage != 3'b111) bad++;
        end
        expect_val("bounce_glitch_cycles", 0);
        observe(bad);
        expect_val("bounce_cause", 0);
        observe(int'(bus.reset_cause));

        // Table of reset events applied from RUN.
        for (int v = 0; v < 6; v++) begin
            unique case (vecs[v].kind)
                0: bus.sw_reset_req = 1'b1;
                1: bus.pll_locked   = 1'b0;
                default: bus.button_n = 1'b0;
            endcase
            expect_val({vecs[v].name, "_drop"}, vecs[v].exp_drop);
            expect_val({vecs[v].name, "_cause"}, vecs[v].exp_cause);
            expect_val({vecs[v].name, "_release"}, vecs[v].exp_rel);
            wait_drop(n);
            observe(n);
            observe(int'(bus.reset_cause));
            repeat (vecs[v].hold) tick();
            bus.pll_locked = 1'b1;
            bus.button_n   = 1'b1;
            wait_rise(0, n);
            observe((n < 0) ? n : n + vecs[v].hold);
            finish_release(vecs[v].name);
        end

        // Lock glitch in WAIT_LOCK restarts the count without a new event.
        // Sync low again at edge E+7, first counting edge E+9 -> stage0 E+24.
        bus.pll_locked = 1'b0;
        expect_val("glitch_drop", 3);
        wait_drop(n);
        observe(n);
        bus.pll_locked = 1'b1;
        repeat (5) tick();
        bus.pll_locked = 1'b0;
        tick();
        bus.pll_locked = 1'b1;
        expect_val("glitch_release", 24);
        wait_rise(0, n);
        observe((n < 0) ? n : n + 6);
        expect_val("glitch_cause", 2);
        observe(int'(bus.reset_cause));
        finish_release("glitch");

        // PLL loss and software request reach the FSM on the same edge.
        bus.pll_locked = 1'b0;
        tick();
        tick();
        bus.sw_reset_req = 1'b1;
        tick();
        bus.sw_reset_req = 1'b0;
        expect_val("simul_stages", 0);
        observe(int'(bus.rst_n_stage));
        expect_val("simul_cause", 2);
        observe(int'(bus.reset_cause));
        bus.pll_locked = 1'b1;
        expect_val("simul_release", 18);
        wait_rise(0, n);
        observe(n);

        // Software request right after stage0 released.
        bus.sw_reset_req = 1'b1;
        tick();
        bus.sw_reset_req = 1'b0;
        expect_val("rel_sw_stage0", 0);
        observe(int'(bus.rst_n_stage[0]));
        expect_val("rel_sw_cause", 3);
        observe(int'(bus.reset_cause));
        expect_val("rel_sw_active", 1);
        observe(int'(bus.reset_active));
        expect_val("rel_sw_release", 17);
        wait_rise(0, n);
        observe(n);
        expect_val("rel_sw_gap1", GAP);
        wait_rise(1, n);
        observe(n);

        // Asynchronous rst_n mid-RELEASE, sampled before the next clock edge.
        rst_n = 1'b0;
        #1;
        expect_val("async_stages", 0);
        observe(int'(bus.rst_n_stage));
        expect_val("async_active", 1);
        observe(int'(bus.reset_active));
        expect_val("async_cause", 0);
        observe(int'(bus.reset_cause));
        repeat (2) tick();
        rst_n = 1'b1;
        expect_val("repor_stage0", 3 + LOCK + HOLD);
        wait_rise(0, n);
        observe(n);
        expect_val("repor_stage2", 2 * GAP);
        wait_rise(2, n);
        observe(n);
        expect_val("repor_active_run", 0);
        observe(int'(bus.reset_active));

        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover: got %0d pending, want 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
